// File: rtl/noc_buf_pkg.sv
// Shared sizing helpers for the multi-VC input buffer: width derivation and
// occupancy-bus slicing.
package noc_buf_pkg;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // A single-VC build still needs a one-bit VC field.
  function automatic int vcWidth(input int numVC);
    return (clog2(numVC) < 1) ? 1 : clog2(numVC);
  endfunction

  // One extra pointer bit separates the full and empty cases.
  function automatic int ptrWidth(input int addressWidth);
    return addressWidth + 1;
  endfunction

  function automatic int occLsb(input int vc, input int addressWidth);
    return vc * ptrWidth(addressWidth);
  endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// One virtual-channel FIFO lane: storage, wrap-bit pointers and status.
// Read data is the unregistered head entry; the caller qualifies it with rdEn.
module vc_fifo_lane
  import noc_buf_pkg::*;
#(
  parameter int dataWidth     = 32,
  parameter int addressWidth  = 4,
  parameter int almostFullThr = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [dataWidth-1:0]  wrData,
  input  logic                  rdEn,
  output logic [dataWidth-1:0]  rdData,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic [addressWidth:0] count
);

  localparam int depth = 1 << addressWidth;
  localparam logic [addressWidth:0] ptrOne = 1;

  logic [dataWidth-1:0]  mem [depth];
  logic [addressWidth:0] wrPtr;
  logic [addressWidth:0] rdPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + ptrOne;
      if (rdEn) rdPtr <= rdPtr + ptrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[addressWidth-1:0]] <= wrData;
  end

  assign rdData     = mem[rdPtr[addressWidth-1:0]];
  assign count      = wrPtr - rdPtr;
  assign empty      = (wrPtr == rdPtr);
  assign full       = (wrPtr[addressWidth] != rdPtr[addressWidth]) &&
                      (wrPtr[addressWidth-1:0] == rdPtr[addressWidth-1:0]);
  assign almostFull = (depth - int'(count)) <= almostFullThr;

endmodule

// File: rtl/vc_input_fifo.sv
// Multi-VC router input buffer: per-VC lanes, write/read VC decode, grant
// registers and the registered read-data mux.
module vc_input_fifo
  import noc_buf_pkg::*;
#(
  parameter int dataWidth     = 32,
  parameter int addressWidth  = 4,
  parameter int numVC         = 4,
  parameter int almostFullThr = 2,
  parameter int pulseMode     = 1,
  localparam int vcW          = vcWidth(numVC)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 reqUpStr,
  input  logic [vcW-1:0]                       wrVc,
  input  logic [dataWidth-1:0]                 PacketIn,
  output logic                                 gntUpStr,
  input  logic                                 reqInCtr,
  input  logic [vcW-1:0]                       rdVc,
  output logic                                 gntInCtr,
  output logic [vcW-1:0]                       gntVc,
  output logic [dataWidth-1:0]                 PacketOut,
  output logic [numVC-1:0]                     full,
  output logic [numVC-1:0]                     empty,
  output logic [numVC-1:0]                     almostFull,
  output logic [numVC*(addressWidth+1)-1:0]    occupancy
);

  localparam int ptrW = ptrWidth(addressWidth);

  logic [numVC-1:0]     wrEnVec;
  logic [numVC-1:0]     rdEnVec;
  logic [dataWidth-1:0] laneRdData [numVC];
  logic [ptrW-1:0]      laneCount  [numVC];
  logic [dataWidth-1:0] rdMux;
  logic                 enableGnt;
  logic                 wrAllowed;
  logic                 wrFire;
  logic                 rdFire;

  // Legacy pulse mode re-arms only after the upstream drops its request.
  assign wrAllowed = (pulseMode == 0) || enableGnt;

  // Out-of-range VC ids match no lane and are therefore ignored.
  for (genvar v = 0; v < numVC; v++) begin : gLane
    assign wrEnVec[v] = reqUpStr && wrAllowed && (wrVc == vcW'(v)) && !full[v];
    assign rdEnVec[v] = reqInCtr && (rdVc == vcW'(v)) && !empty[v];

    vc_fifo_lane #(
      .dataWidth    (dataWidth),
      .addressWidth (addressWidth),
      .almostFullThr(almostFullThr)
    ) uLane (
      .clk       (clk),
      .reset     (reset),
      .wrEn      (wrEnVec[v]),
      .wrData    (PacketIn),
      .rdEn      (rdEnVec[v]),
      .rdData    (laneRdData[v]),
      .full      (full[v]),
      .empty     (empty[v]),
      .almostFull(almostFull[v]),
      .count     (laneCount[v])
    );

    assign occupancy[occLsb(v, addressWidth) +: ptrW] = laneCount[v];
  end

  assign wrFire = |wrEnVec;
  assign rdFire = |rdEnVec;

  always_comb begin
    rdMux = '0;
    for (int v = 0; v < numVC; v++) begin
      if (rdEnVec[v]) rdMux = laneRdData[v];
    end
  end

  // Grant / output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      enableGnt <= 1'b1;
      gntUpStr  <= 1'b0;
      gntInCtr  <= 1'b0;
      gntVc     <= '0;
      PacketOut <= '0;
    end else begin
      gntUpStr <= wrFire;
      gntInCtr <= rdFire;
      if (wrFire)         enableGnt <= 1'b0;
      else if (!reqUpStr) enableGnt <= 1'b1;
      if (rdFire) begin
        PacketOut <= rdMux;
        gntVc     <= rdVc;
      end
    end
  end

endmodule
